// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the i-cache, d-cache and main-memory block-port signals
//          seen by mem_port_arbiter, plus the conflict counter output.
// Ports:   slave  = arbiter view (takes cache requests, drives the memory)
//          master = environment view (caches + memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  // i-cache refill side
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  // d-cache refill / write-back side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  // backing memory block port
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  // arbitration statistics
  logic [CNT_W-1:0]  conflict_count;

  modport slave (
    input  i_read, i_address,
    output i_readdata, i_busywait,
    input  d_read, d_write, d_address, d_writedata,
    output d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait,
    output conflict_count
  );

  modport master (
    output i_read, i_address,
    input  i_readdata, i_busywait,
    output d_read, d_write, d_address, d_writedata,
    input  d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait,
    input  conflict_count
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one main-memory block port between i-cache and d-cache,
//          round-robin on simultaneous requests, one access in flight.
// Latency: request seen in IDLE -> 2+ cycles ACCESS -> 1 cycle RELEASE
//          (busywait low 3 cycles after the request with a zero-wait memory).
// Backpressure: busywait protocol; a requester holds its request while its
//          busywait is high, the non-owner stays stalled for the whole access.
// Ports:   clk, reset (async, active-high), bus (mem_port_arbiter_if.slave)
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_I_ACCESS = 2'd1,
    ST_D_ACCESS = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              grant_q, grant_d;           // current owner, 1 = D
  logic              last_grant_q, last_grant_d; // previous owner, 1 = D
  logic              started_q, started_d;       // first ACCESS edge seen
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]  conflict_q, conflict_d;

  logic              i_pend;
  logic              d_pend;
  logic              pick_d;

  assign i_pend = bus.i_read;
  assign d_pend = bus.d_read || bus.d_write;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      started_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      conflict_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      started_q    <= started_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      conflict_q   <= conflict_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and memory-port outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    started_d     = started_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    conflict_d    = conflict_q;
    pick_d        = 1'b0;

    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_pend && d_pend && (conflict_q != CNT_MAX)) begin
          conflict_d = conflict_q + CNT_ONE;
        end
        if (i_pend || d_pend) begin
          // With both pending, the side that did not win last time goes.
          pick_d       = d_pend && (!i_pend || !last_grant_q);
          grant_d      = pick_d;
          last_grant_d = pick_d;
          started_d    = 1'b0;
          state_d      = pick_d ? ST_D_ACCESS : ST_I_ACCESS;
        end
      end

      ST_I_ACCESS: begin
        // Strobes follow the live request so a withdrawn request drops them.
        bus.mem_read    = bus.i_read;
        bus.mem_address = bus.i_address;
        started_d       = 1'b1;
        // started_q masks a stale busywait-low on the first cycle.
        if (started_q && !bus.mem_busywait) begin
          if (bus.i_read) begin
            i_rdata_d = bus.mem_readdata;
          end
          started_d = 1'b0;
          state_d   = ST_RELEASE;
        end
      end

      ST_D_ACCESS: begin
        bus.mem_read      = bus.d_read;
        bus.mem_write     = bus.d_write;
        bus.mem_address   = bus.d_address;
        bus.mem_writedata = bus.d_writedata;
        started_d         = 1'b1;
        if (started_q && !bus.mem_busywait) begin
          if (bus.d_read) begin
            d_rdata_d = bus.mem_readdata;
          end
          started_d = 1'b0;
          state_d   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // No back-to-back grant: a fresh arbitration always happens in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Cache-side outputs
  // ---------------------------------------------------------------------
  // Busywait drops only for the owner, only during RELEASE.
  assign bus.i_busywait = i_pend && !((state_q == ST_RELEASE) && !grant_q);
  assign bus.d_busywait = d_pend && !((state_q == ST_RELEASE) &&  grant_q);

  assign bus.i_readdata     = i_rdata_q;
  assign bus.d_readdata     = d_rdata_q;
  assign bus.conflict_count = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed bench for mem_port_arbiter with a variable-wait memory
//          model and per-test hand-computed expectations.
// Latency: n/a (testbench)
// Backpressure: requesters follow the busywait protocol
module tb_mem_port_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  int mem_wait;
  int mem_cnt;

  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    if (a == 28'h0000010) return {32{4'hA}};
    return {4{4'hC, a}};
  endfunction

  always @(posedge clk) begin
    if (!(bus.mem_read || bus.mem_write)) mem_cnt <= 0;
    else                                  mem_cnt <= mem_cnt + 1;
  end

  assign bus.mem_readdata = mem_data(bus.mem_address);
  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (mem_cnt < mem_wait);

  // ---------------- checking ----------------
  int n_total;
  int n_bad;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- requester driver / observer ----------------
  int                i_left, d_left;
  int                i_lat, d_lat, i_low, d_low;
  int                strobe_cyc, write_cyc;
  logic [DATA_W-1:0] i_got, d_got, last_wdata;
  logic [ADDR_W-1:0] acc_addr[$];
  int                i_fin_accs;  // accesses started when I first finished

  task automatic start(input int in, input logic [ADDR_W-1:0] ia,
                       input int dn, input logic [ADDR_W-1:0] da,
                       input bit dw, input logic [DATA_W-1:0] dwd);
    @(posedge clk); #1;
    i_left = in; d_left = dn;
    i_lat = -1; d_lat = -1; i_low = 0; d_low = 0;
    strobe_cyc = 0; write_cyc = 0; i_fin_accs = -1;
    i_got = '0; d_got = '0; last_wdata = '0;
    acc_addr.delete();
    bus.i_read      = (in > 0);
    bus.i_address   = ia;
    bus.d_read      = (dn > 0) && !dw;
    bus.d_write     = (dn > 0) && dw;
    bus.d_address   = da;
    bus.d_writedata = dwd;
  endtask

  task automatic run(input int budget);
    int  c;
    bit  prev_strobe, strobe, i_fin, d_fin;
    c = 0;
    prev_strobe = 1'b0;
    while ((bus.i_read || bus.d_read || bus.d_write) && (c < budget)) begin
      @(negedge clk);
      strobe = bus.mem_read || bus.mem_write;
      if (strobe && !prev_strobe) acc_addr.push_back(bus.mem_address);
      if (strobe) strobe_cyc++;
      if (bus.mem_write) begin
        write_cyc++;
        last_wdata = bus.mem_writedata;
      end
      prev_strobe = strobe;
      i_fin = bus.i_read && !bus.i_busywait;
      d_fin = (bus.d_read || bus.d_write) && !bus.d_busywait;
      if (i_fin) begin
        if (i_lat < 0) begin
          i_lat = c;
          i_fin_accs = acc_addr.size();
        end
        i_low++;
        i_got = bus.i_readdata;
      end
      if (d_fin) begin
        if (d_lat < 0) d_lat = c;
        d_low++;
        d_got = bus.d_readdata;
      end
      c++;
      @(posedge clk); #1;
      if (i_fin) begin
        i_left--;
        if (i_left == 0) bus.i_read = 1'b0;
        else             bus.i_address = bus.i_address + 1'b1;
      end
      if (d_fin) begin
        d_left--;
        if (d_left == 0) begin
          bus.d_read  = 1'b0;
          bus.d_write = 1'b0;
        end else begin
          bus.d_address = bus.d_address + 1'b1;
        end
      end
    end
    check("run_pending", {126'b0, bus.i_read, bus.d_read || bus.d_write}, '0);
    bus.i_read  = 1'b0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_total = 0; n_bad = 0;
    mem_wait = 0;
    reset = 1'b1;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.d_address = '0; bus.d_writedata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_mem_read",  {127'b0, bus.mem_read},  '0);
    check("rst_mem_write", {127'b0, bus.mem_write}, '0);
    check("rst_i_rdata",   bus.i_readdata, '0);
    check("rst_d_rdata",   bus.d_readdata, '0);
    check("rst_conflict",  {124'b0, bus.conflict_count}, '0);

    // T1: single I read, memory busy 3 cycles
    mem_wait = 3;
    start(1, 28'h0000010, 0, '0, 1'b0, '0);
    run(40);
    check("t1_i_lat",      i_lat, 5);
    check("t1_strobe_cyc", strobe_cyc, 4);
    check("t1_write_cyc",  write_cyc, 0);
    check("t1_nacc",       acc_addr.size(), 1);
    check("t1_addr",       acc_addr[0], 28'h0000010);
    check("t1_i_rdata",    i_got, {32{4'hA}});
    check("t1_d_rdata",    bus.d_readdata, '0);

    // T3: I and D rise together from reset, D wins first
    pulse_reset();
    mem_wait = 0;
    start(1, 28'h0000400, 1, 28'h0000300, 1'b0, '0);
    run(60);
    check("t3_nacc",       acc_addr.size(), 2);
    check("t3_first",      acc_addr[0], 28'h0000300);
    check("t3_second",     acc_addr[1], 28'h0000400);
    check("t3_d_lat",      d_lat, 3);
    check("t3_i_lat",      i_lat, 7);
    check("t3_i_after",    i_fin_accs, 2);
    check("t3_d_rdata",    d_got, 128'hC0000300_C0000300_C0000300_C0000300);
    check("t3_i_rdata",    i_got, 128'hC0000400_C0000400_C0000400_C0000400);
    check("t3_conflict",   {124'b0, bus.conflict_count}, 1);

    // T4: continuous re-requests, two accesses each
    start(2, 28'h0000200, 2, 28'h0000100, 1'b0, '0);
    run(100);
    check("t4_nacc",       acc_addr.size(), 4);
    check("t4_g0",         acc_addr[0], 28'h0000100);
    check("t4_g1",         acc_addr[1], 28'h0000200);
    check("t4_g2",         acc_addr[2], 28'h0000101);
    check("t4_g3",         acc_addr[3], 28'h0000201);
    check("t4_i_rdata",    bus.i_readdata, 128'hC0000201_C0000201_C0000201_C0000201);
    check("t4_d_rdata",    bus.d_readdata, 128'hC0000101_C0000101_C0000101_C0000101);
    check("t4_conflict",   {124'b0, bus.conflict_count}, 4);

    // T2: D write-back
    start(0, '0, 1, 28'h0000020, 1'b1, {4{32'h1234_5678}});
    run(40);
    check("t2_addr",       acc_addr[0], 28'h0000020);
    check("t2_write_cyc",  write_cyc, 2);
    check("t2_wdata",      last_wdata, {4{32'h1234_5678}});
    check("t2_d_lat",      d_lat, 3);
    check("t2_d_low",      d_low, 1);
    check("t2_i_rdata",    bus.i_readdata, 128'hC0000201_C0000201_C0000201_C0000201);
    check("t2_d_rdata",    bus.d_readdata, 128'hC0000101_C0000101_C0000101_C0000101);

    // T5: reset mid D access
    mem_wait = 5;
    start(0, '0, 1, 28'h0000500, 1'b0, '0);
    @(negedge clk);                 // IDLE
    @(negedge clk);                 // D_ACCESS
    check("t5_pre_read",   {127'b0, bus.mem_read}, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_mem_read",   {127'b0, bus.mem_read}, '0);
    check("t5_i_rdata",    bus.i_readdata, '0);
    check("t5_d_rdata",    bus.d_readdata, '0);
    check("t5_conflict",   {124'b0, bus.conflict_count}, '0);
    bus.d_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // T6: 21 conflicting arbitrations saturate the 4-bit counter
    mem_wait = 0;
    start(11, 28'h0001000, 11, 28'h0002000, 1'b0, '0);
    run(400);
    check("t6_nacc",       acc_addr.size(), 22);
    check("t6_conflict",   {124'b0, bus.conflict_count}, 15);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory block port between the i-cache refill path and the d-cache refill/write-back path.
- Sits between both caches and the backing memory model; one access is in flight at a time.
- Requesters keep the codebase busywait protocol: hold the request, stall while busywait is high.
- Round-robin on simultaneous requests; a saturating counter records conflict cycles.

Parameters:
ADDR_W, 28, block address width (byte address >> 4)
DATA_W, 128, block data width (4 words)
CNT_W, 16, conflict counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_read  in  1  i-cache block read request, held until i_busywait low
i_address  in  ADDR_W  i-cache block address
i_readdata  out  DATA_W  block returned to i-cache
i_busywait  out  1  stall to i-cache
d_read  in  1  d-cache block read request
d_write  in  1  d-cache block write-back request; d_read and d_write are never both high
d_address  in  ADDR_W  d-cache block address
d_writedata  in  DATA_W  write-back block
d_readdata  out  DATA_W  block returned to d-cache
d_busywait  out  1  stall to d-cache
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_W  memory block address
mem_writedata  out  DATA_W  memory write data
mem_readdata  in  DATA_W  memory read data
mem_busywait  in  1  memory busy; low = access complete
conflict_count  out  CNT_W  cycles in IDLE with both requesters pending (saturating)

Behaviour:
- Reset (async, active-high): state=IDLE, last_grant=I, i_readdata=0, d_readdata=0, conflict_count=0, all mem strobes 0, started=0.
- States: IDLE, I_ACCESS, D_ACCESS, RELEASE. Register grant_d (1=D) holds the current owner.
- IDLE
  - Only D pending: go to D_ACCESS.
  - Only I pending: go to I_ACCESS.
  - Both pending: grant the side opposite last_grant.
  - None pending: stay in IDLE.
  - last_grant updates on the grant edge.
- x_ACCESS
  - mem_read/mem_write/mem_address/mem_writedata are driven combinationally from the owner's live request signals.
  - I_ACCESS drives mem_write=0 and mem_writedata=0.
  - started is set on the first edge in the state.
  - Completion edge: started==1 and mem_busywait==0. This guarantees a minimum of 2 cycles in the state.
  - On completion, if the owner's access is a read, capture mem_readdata into that requester's readdata register; the other register holds. Clear started; go to RELEASE.
- RELEASE
  - One cycle; mem strobes are 0.
  - Owner's busywait is 0 in this cycle, so the requester samples readdata and drops its request.
  - Always go to IDLE next; there is no back-to-back grant from RELEASE.
- Busywait outputs (combinational)
  - i_busywait = i_read && !(state==RELEASE && !grant_d).
  - d_busywait = (d_read||d_write) && !(state==RELEASE && grant_d).
  - A non-owner stays stalled for the whole access.
- Request withdrawn during x_ACCESS (not legal in the protocol): the strobes fall with it. The FSM still waits for completion and then passes through RELEASE.
- Reset asserted mid-access: immediate return to IDLE with the strobes low. Readdata registers are cleared and the memory transaction is abandoned.
- conflict_count increments on each edge where state==IDLE and both requesters are pending. It saturates at 2^CNT_W-1.
- readdata registers hold their value between accesses.
- Minimum latency from request to busywait low: request in IDLE at cycle 0, ACCESS at cycles 1-2, RELEASE at cycle 3 (memory with zero wait).

Test Plan:
- Single I read, addr 0x0000010, memory busy 3 cycles, returns 0xAAAA...A → mem_read high during I_ACCESS only. i_readdata=0xAAAA...A when i_busywait falls. d_readdata remains 0.
- D write-back, addr 0x0000020, data 0x1234...5678 → mem_write=1, mem_writedata=0x1234...5678 during D_ACCESS. d_busywait low exactly 1 cycle. Both readdata registers unchanged.
- I and D requests rise in the same cycle from reset → D granted first (last_grant=I after reset). I is served second. conflict_count=1. i_busywait is never low before the I access completes.
- I and D continuously re-request for 4 accesses → grants alternate D,I,D,I. conflict_count increments once per arbitration.
- Reset pulsed during D_ACCESS → within the same cycle the state is IDLE and mem_read=0. Both readdata are 0 and conflict_count=0.
- Drive the conflict condition for 2^CNT_W+5 arbitrations with CNT_W=4 → conflict_count holds at 15.
